// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port general-purpose register file.
package regfile_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;

   // Register $0 is architecturally fixed to zero.
   localparam int REG_ZERO = 0;

   typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
   typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets a bit, a committed write clears it,
// and a same-cycle issue beats the clear because it names the younger producer.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [(1<<ADDR_W)-1:0]   clr_i,
   input  logic                     iss_en_i,
   input  logic [ADDR_W-1:0]        iss_addr_i,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD-1:0]        rd_busy_o
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic [ADDR_W-1:0] rdAddr [NUM_RD];

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rdAddr
      assign rdAddr[i] = rd_addr_i[i*ADDR_W +: ADDR_W];
   end

   always_comb begin
      busy_d = busy_q & ~clr_i;
      if (iss_en_i && int'(iss_addr_i) != REG_ZERO) begin
         busy_d[iss_addr_i] = 1'b1;
      end
      busy_d[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // With bypass, a reader already sees the retiring value, so it must not stall on it.
   always_comb begin
      rd_busy_o = '0;
      if (!reset) begin
         for (int i = 0; i < NUM_RD; i++) begin
            rd_busy_o[i] = busy_q[rdAddr[i]];
            if (BYPASS != 0 && clr_i[rdAddr[i]]) begin
               rd_busy_o[i] = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with highest-port-wins write arbitration and write-to-read bypass.
// Optional write trace enabled by defining REGFILE_TRACE_EN.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD*DATA_W-1:0] rd_data_o,
   output logic [NUM_RD-1:0]        rd_busy_o,
   input  logic [NUM_WR-1:0]        wr_en_i,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
   input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
   input  logic [NUM_WR*32-1:0]     wr_pc_i,
   input  logic                     iss_en_i,
   input  logic [ADDR_W-1:0]        iss_addr_i
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regFile_q [DEPTH];
   logic [DATA_W-1:0] regFile_d [DEPTH];
   logic [ADDR_W-1:0] rdAddr    [NUM_RD];
   logic [ADDR_W-1:0] wrAddr    [NUM_WR];
   logic [DATA_W-1:0] wrData    [NUM_WR];
   logic [NUM_WR-1:0] wrWin;
   logic [DEPTH-1:0]  clrMask;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rdAddr
      assign rdAddr[i] = rd_addr_i[i*ADDR_W +: ADDR_W];
   end

   for (genvar j = 0; j < NUM_WR; j++) begin : g_wrPort
      assign wrAddr[j] = wr_addr_i[j*ADDR_W +: ADDR_W];
      assign wrData[j] = wr_data_i[j*DATA_W +: DATA_W];
   end

   // A port commits only if no higher-index port targets the same register.
   always_comb begin
      wrWin   = '0;
      clrMask = '0;
      if (!reset) begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j] && int'(wrAddr[j]) != REG_ZERO) begin
               wrWin[j]             = 1'b1;
               clrMask[wrAddr[j]]   = 1'b1;
               for (int k = j + 1; k < NUM_WR; k++) begin
                  if (wr_en_i[k] && wrAddr[k] == wrAddr[j]) begin
                     wrWin[j] = 1'b0;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      regFile_d = regFile_q;
      for (int j = 0; j < NUM_WR; j++) begin
         if (wrWin[j]) begin
            regFile_d[wrAddr[j]] = wrData[j];
         end
      end
      regFile_d[REG_ZERO] = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < DEPTH; r++) begin
            regFile_q[r] <= '0;
         end
      end else begin
         regFile_q <= regFile_d;
      end
   end

   // Ascending scan lets the highest-index matching port override the forwarded value.
   always_comb begin
      rd_data_o = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (int'(rdAddr[i]) != REG_ZERO) begin
            rd_data_o[i*DATA_W +: DATA_W] = regFile_q[rdAddr[i]];
            if (BYPASS != 0 && !reset) begin
               for (int j = 0; j < NUM_WR; j++) begin
                  if (wr_en_i[j] && wrAddr[j] == rdAddr[i]) begin
                     rd_data_o[i*DATA_W +: DATA_W] = wrData[j];
                  end
               end
            end
         end
      end
   end

   regfile_scoreboard #(
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD),
      .BYPASS (BYPASS)
   ) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (clrMask),
      .iss_en_i   (iss_en_i),
      .iss_addr_i (iss_addr_i),
      .rd_addr_i  (rd_addr_i),
      .rd_busy_o  (rd_busy_o)
   );

`ifdef REGFILE_TRACE_EN
   always @(posedge clk) begin
      if (!reset) begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (wrWin[j]) begin
               $display("%d@%h: $%d <= %h", $time, wr_pc_i[j*32 +: 32], wrAddr[j], wrData[j]);
            end
         end
      end
   end
`else
   logic unusedPc;
   assign unusedPc = ^wr_pc_i;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp; a BYPASS=0 twin shares all inputs.
module tb_regfile_mp;
   import regfile_pkg::*;

   logic        clk;
   logic        reset;
   logic [9:0]  rdAddr;
   logic [63:0] rdData;
   logic [1:0]  rdBusy;
   logic [63:0] rdDataNb;
   logic [1:0]  rdBusyNb;
   logic [1:0]  wrEn;
   logic [9:0]  wrAddr;
   logic [63:0] wrData;
   logic [63:0] wrPc;
   logic        issEn;
   reg_addr_t   issAddr;

   int total = 0;
   int bad   = 0;

   regfile_mp #(.BYPASS(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .rd_addr_i  (rdAddr),
      .rd_data_o  (rdData),
      .rd_busy_o  (rdBusy),
      .wr_en_i    (wrEn),
      .wr_addr_i  (wrAddr),
      .wr_data_i  (wrData),
      .wr_pc_i    (wrPc),
      .iss_en_i   (issEn),
      .iss_addr_i (issAddr)
   );

   regfile_mp #(.BYPASS(0)) dutNb (
      .clk        (clk),
      .reset      (reset),
      .rd_addr_i  (rdAddr),
      .rd_data_o  (rdDataNb),
      .rd_busy_o  (rdBusyNb),
      .wr_en_i    (wrEn),
      .wr_addr_i  (wrAddr),
      .wr_data_i  (wrData),
      .wr_pc_i    (wrPc),
      .iss_en_i   (issEn),
      .iss_addr_i (issAddr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] en, input reg_addr_t a0, input reg_data_t d0,
                                input reg_addr_t a1, input reg_data_t d1);
      wrEn   = en;
      wrAddr = {a1, a0};
      wrData = {d1, d0};
      wrPc   = {32'h0040_0004, 32'h0040_0000};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset   = 1'b1;
      rdAddr  = '0;
      issEn   = 1'b0;
      issAddr = '0;
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      tick();
      tick();
      reset = 1'b0;
      #1;

      for (int a = 0; a < 32; a++) begin
         rdAddr = {5'(31 - a), 5'(a)};
         #1;
         checkOutput("reset data p0", rdData[31:0], 32'h0);
         checkOutput("reset data p1", rdData[63:32], 32'h0);
         checkOutput("reset busy", {30'h0, rdBusy}, 32'h0);
      end

      rdAddr = {5'd0, 5'd5};
      applyStimulus(2'b01, 5'd5, 32'h1234_5678, 5'd0, 32'h0);
      #1;
      checkOutput("bypass same cycle", rdData[31:0], 32'h1234_5678);
      checkOutput("nobypass old value", rdDataNb[31:0], 32'h0);
      tick();
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      #1;
      checkOutput("array after write", rdData[31:0], 32'h1234_5678);
      checkOutput("nobypass next cycle", rdDataNb[31:0], 32'h1234_5678);

      rdAddr = {5'd7, 5'd7};
      applyStimulus(2'b11, 5'd7, 32'hAAAA_AAAA, 5'd7, 32'h5555_5555);
      #1;
      checkOutput("conflict bypass", rdData[31:0], 32'h5555_5555);
      tick();
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      #1;
      checkOutput("conflict winner", rdData[63:32], 32'h5555_5555);
      checkOutput("conflict winner nb", rdDataNb[31:0], 32'h5555_5555);

      applyStimulus(2'b11, 5'd3, 32'h0000_0011, 5'd4, 32'h0000_0022);
      tick();
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      rdAddr = {5'd4, 5'd3};
      #1;
      checkOutput("dual write p0", rdData[31:0], 32'h0000_0011);
      checkOutput("dual write p1", rdData[63:32], 32'h0000_0022);

      rdAddr  = {5'd0, 5'd0};
      applyStimulus(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0);
      issEn   = 1'b1;
      issAddr = 5'd0;
      #1;
      checkOutput("zero bypass", rdData[31:0], 32'h0);
      tick();
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      issEn = 1'b0;
      #1;
      checkOutput("zero read", rdData[31:0], 32'h0);
      checkOutput("zero busy", {30'h0, rdBusy}, 32'h0);

      rdAddr  = {5'd0, 5'd9};
      issEn   = 1'b1;
      issAddr = 5'd9;
      tick();
      issEn = 1'b0;
      tick();
      checkOutput("issue busy", {31'h0, rdBusy[0]}, 32'h1);
      checkOutput("issue busy nb", {31'h0, rdBusyNb[0]}, 32'h1);

      issEn = 1'b1;
      applyStimulus(2'b10, 5'd0, 32'h0, 5'd9, 32'h0000_0042);
      #1;
      checkOutput("write forces idle", {31'h0, rdBusy[0]}, 32'h0);
      checkOutput("write bypass $9", rdData[31:0], 32'h0000_0042);
      tick();
      issEn = 1'b0;
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      #1;
      checkOutput("set beats clear", {31'h0, rdBusy[0]}, 32'h1);
      checkOutput("set beats clear nb", {31'h0, rdBusyNb[0]}, 32'h1);
      checkOutput("$9 value", rdData[31:0], 32'h0000_0042);

      rdAddr = {5'd9, 5'd5};
      reset  = 1'b1;
      applyStimulus(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0);
      #1;
      checkOutput("reset blocks bypass", rdData[31:0], 32'h1234_5678);
      checkOutput("reset masks busy", {30'h0, rdBusy}, 32'h0);
      tick();
      reset = 1'b0;
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      #1;
      checkOutput("reset no commit", rdData[31:0], 32'h0);
      checkOutput("reset clears $9", rdData[63:32], 32'h0);
      checkOutput("reset drops busy", {30'h0, rdBusy}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
